// File: rtl/branch_resolver.sv
// Branch resolution unit with a direct-mapped bimodal predictor.
//
// Ports:
//   clk, reset            - clock; asynchronous active-low reset
//   lk_pc / lk_taken      - fetch-stage lookup: prediction for lk_pc (combinational)
//   rs_valid, rs_kill     - resolving instruction present / discard it
//   rs_pc, rs_rd1, rs_rd2 - instruction PC and source operands
//   rs_imm                - sign-extended immediate
//   rs_type               - branch kind: 0 NoBranch, 1 eq, 2 ne, 3 less_s, 4 less_u,
//                           5 ge_s, 6 ge_u, 7 jal, 8 jalr (9..15 treated as NoBranch)
//   rs_pred               - prediction used by fetch for this instruction
//   rd_valid, rd_flush    - registered one-cycle redirect pulse
//   rd_pc                 - registered redirect target
//   st_branches, st_mispred - saturating event counters
module branch_resolver #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CTR_BITS  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  input  logic            rs_valid,
  input  logic            rs_kill,
  input  logic [XLEN-1:0] rs_pc,
  input  logic [XLEN-1:0] rs_rd1,
  input  logic [XLEN-1:0] rs_rd2,
  input  logic [XLEN-1:0] rs_imm,
  input  logic [3:0]      rs_type,
  input  logic            rs_pred,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc,
  output logic            rd_flush,
  output logic [31:0]     st_branches,
  output logic [31:0]     st_mispred
);

  typedef enum logic [3:0] {
    NoBranch = 4'd0,
    BrEq     = 4'd1,
    BrNe     = 4'd2,
    BrLtS    = 4'd3,
    BrLtU    = 4'd4,
    BrGeS    = 4'd5,
    BrGeU    = 4'd6,
    BrJal    = 4'd7,
    BrJalr   = 4'd8
  } branch_type_e;

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];
  logic                rd_valid_q;
  logic [XLEN-1:0]     rd_pc_q;
  logic [31:0]         st_branches_q;
  logic [31:0]         st_mispred_q;

  branch_type_e        br_type;
  logic                is_branch, is_cond, is_jalr;
  logic                act_taken, mispred, accept;
  logic [XLEN-1:0]     taken_tgt, fall_tgt, redirect_pc;
  logic [IdxW-1:0]     lk_idx, rs_idx;
  logic [CTR_BITS-1:0] ctr_cur, ctr_nxt;

  assign lk_idx = lk_pc[IdxW+1:2];
  assign rs_idx = rs_pc[IdxW+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[XLEN-1:IdxW+2], lk_pc[1:0]};

  // Table is read before this cycle's update lands, so same-index lookups see the old value.
  assign lk_taken = bht_q[lk_idx][CTR_BITS-1];

  assign br_type = branch_type_e'(rs_type);

  always_comb begin
    is_branch = 1'b1;
    is_cond   = 1'b1;
    is_jalr   = 1'b0;
    act_taken = 1'b0;
    unique case (br_type)
      BrEq:    act_taken = (rs_rd1 == rs_rd2);
      BrNe:    act_taken = (rs_rd1 != rs_rd2);
      BrLtS:   act_taken = ($signed(rs_rd1) < $signed(rs_rd2));
      BrLtU:   act_taken = (rs_rd1 < rs_rd2);
      BrGeS:   act_taken = ($signed(rs_rd1) >= $signed(rs_rd2));
      BrGeU:   act_taken = (rs_rd1 >= rs_rd2);
      BrJal: begin
        act_taken = 1'b1;
        is_cond   = 1'b0;
      end
      BrJalr: begin
        act_taken = 1'b1;
        is_cond   = 1'b0;
        is_jalr   = 1'b1;
      end
      default: begin
        is_branch = 1'b0;
        is_cond   = 1'b0;
      end
    endcase
  end

  always_comb begin
    taken_tgt = is_jalr ? ((rs_rd1 + rs_imm) & ~XLEN'(1)) : (rs_pc + rs_imm);
    fall_tgt  = rs_pc + XLEN'(4);
    // jalr target is never predicted by the table, so it always redirects.
    mispred     = is_jalr | (act_taken != rs_pred);
    redirect_pc = act_taken ? taken_tgt : fall_tgt;
    accept      = rs_valid & ~rs_kill & is_branch;
  end

  always_comb begin
    ctr_cur = bht_q[rs_idx];
    ctr_nxt = ctr_cur;
    if (act_taken) begin
      if (ctr_cur != {CTR_BITS{1'b1}}) ctr_nxt = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= CtrInit;
    end else if (accept && is_cond) begin
      bht_q[rs_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q    <= 1'b0;
      rd_pc_q       <= '0;
      st_branches_q <= '0;
      st_mispred_q  <= '0;
    end else begin
      rd_valid_q <= accept & mispred;
      if (accept && mispred) rd_pc_q <= redirect_pc;
      if (accept && st_branches_q != 32'hFFFF_FFFF) st_branches_q <= st_branches_q + 32'd1;
      if (accept && mispred && st_mispred_q != 32'hFFFF_FFFF) begin
        st_mispred_q <= st_mispred_q + 32'd1;
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_flush    = rd_valid_q;
  assign rd_pc       = rd_pc_q;
  assign st_branches = st_branches_q;
  assign st_mispred  = st_mispred_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam logic [3:0] NoBr = 4'd0, BEq = 4'd1, BNe = 4'd2, BLtS = 4'd3, BLtU = 4'd4,
                         BGeS = 4'd5, BGeU = 4'd6, BJal = 4'd7, BJalr = 4'd8;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, reset;
  logic [63:0] lk_pc;
  logic        lk_taken;
  logic        rs_valid, rs_kill, rs_pred;
  logic [63:0] rs_pc, rs_rd1, rs_rd2, rs_imm;
  logic [3:0]  rs_type;
  logic        rd_valid, rd_flush;
  logic [63:0] rd_pc;
  logic [31:0] st_branches, st_mispred;

  int n_checks = 0;
  int n_errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  branch_resolver #(.XLEN(64), .BHT_DEPTH(64), .CTR_BITS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .lk_pc       (lk_pc),
    .lk_taken    (lk_taken),
    .rs_valid    (rs_valid),
    .rs_kill     (rs_kill),
    .rs_pc       (rs_pc),
    .rs_rd1      (rs_rd1),
    .rs_rd2      (rs_rd2),
    .rs_imm      (rs_imm),
    .rs_type     (rs_type),
    .rs_pred     (rs_pred),
    .rd_valid    (rd_valid),
    .rd_pc       (rd_pc),
    .rd_flush    (rd_flush),
    .st_branches (st_branches),
    .st_mispred  (st_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  typ;
    logic [63:0] rd1, rd2, pc, imm;
    logic        pred;
    logic        acc;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] typ, input logic [63:0] rd1, input logic [63:0] rd2,
                       input logic [63:0] pc, input logic [63:0] imm, input logic pred);
    rs_valid = 1'b1;
    rs_type  = typ;
    rs_rd1   = rd1;
    rs_rd2   = rd2;
    rs_pc    = pc;
    rs_imm   = imm;
    rs_pred  = pred;
  endtask

  task automatic idle();
    rs_valid = 1'b0;
    rs_kill  = 1'b0;
    rs_type  = NoBr;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_st_branches"}, 64'(st_branches), 64'(exp_br));
    chk({tag, "_st_mispred"}, 64'(st_mispred), 64'(exp_mp));
  endtask

  // Taken/not-taken updates at 0x104 with correct predictions; expected lk_taken after each.
  logic seq_tk  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic seq_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    //            name          typ   rd1                    rd2   pc                     imm                    pr acc v  exp_pc
    vecs.push_back('{"bltu_max",  BLtU, 64'd1,                 Ones, 64'h900,               64'h40,                1, 1, 0, 64'h0});
    vecs.push_back('{"blt_neg",   BLtS, 64'd1,                 Ones, 64'h900,               64'h40,                0, 1, 0, 64'h0});
    vecs.push_back('{"jalr_clr",  BJalr,64'h2001,              64'd0,64'h104,               64'h10,                0, 1, 1, 64'h2010});
    vecs.push_back('{"bne_ntk",   BNe,  64'd3,                 64'd3,64'h200,               64'h40,                1, 1, 1, 64'h204});
    vecs.push_back('{"bge_s_neg", BGeS, 64'hFFFF_FFFF_FFFF_FFFB,64'd2,64'h300,              64'h20,                1, 1, 1, 64'h304});
    vecs.push_back('{"bge_u_neg", BGeU, 64'hFFFF_FFFF_FFFF_FFFB,64'd2,64'h400,              64'hFFFF_FFFF_FFFF_FFF0,0, 1, 1, 64'h3F0});
    vecs.push_back('{"jal_ok",    BJal, 64'd0,                 64'd0,64'h500,               64'h100,               1, 1, 0, 64'h0});
    vecs.push_back('{"jal_mis",   BJal, 64'd0,                 64'd0,64'h600,               64'h8,                 0, 1, 1, 64'h608});
    vecs.push_back('{"beq_hi",    BEq,  64'h1_0000_0005,       64'd5,64'h700,               64'h80,                1, 1, 1, 64'h704});
    vecs.push_back('{"bltu_wrap", BLtU, 64'd0,                 64'd1,64'hFFFF_FFFF_FFFF_FFFC,64'h8,                0, 1, 1, 64'h4});
    vecs.push_back('{"bne_fwrap", BNe,  64'd9,                 64'd9,64'hFFFF_FFFF_FFFF_FFFE,64'h10,               1, 1, 1, 64'h2});
    vecs.push_back('{"bge_eq",    BGeS, 64'd7,                 64'd7,64'h800,               64'h10,                0, 1, 1, 64'h810});
    vecs.push_back('{"nobranch",  NoBr, 64'd0,                 64'd1,64'h900,               64'h10,                1, 0, 0, 64'h0});
    vecs.push_back('{"jalr_pred", BJalr,64'h3000,              64'd0,64'h108,               64'hFFFF_FFFF_FFFF_FFFC,1, 1, 1, 64'h2FFC});
    vecs.push_back('{"blt_yes",   BLtS, 64'hFFFF_FFFF_FFFF_FFFD,64'd4,64'hA00,              64'h20,                0, 1, 1, 64'hA20});
    vecs.push_back('{"bltu_no",   BLtU, 64'hFFFF_FFFF_FFFF_FFFD,64'd4,64'hB00,              64'h20,                1, 1, 1, 64'hB04});

    reset = 1'b0;
    lk_pc = 64'h0;
    rs_pc = '0; rs_rd1 = '0; rs_rd2 = '0; rs_imm = '0; rs_pred = 1'b0;
    idle();
    step();
    step();

    // Reset state
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_flush", 64'(rd_flush), 64'd0);
    chk("rst_rd_pc", rd_pc, 64'h0);
    chk_stats("rst");
    chk("rst_lk_taken", 64'(lk_taken), 64'd0);
    reset = 1'b1;
    step();

    // beq taken, predicted not-taken
    drive(BEq, 64'd5, 64'd5, 64'h100, 64'h20, 1'b0);
    step();
    exp_br++; exp_mp++;
    idle();
    chk("beq_rd_valid", 64'(rd_valid), 64'd1);
    chk("beq_rd_flush", 64'(rd_flush), 64'd1);
    chk("beq_rd_pc", rd_pc, 64'h120);
    chk_stats("beq");
    step();
    chk("beq_pulse_end", 64'(rd_valid), 64'd0);

    // Table of single-cycle resolutions, applied back to back
    foreach (vecs[i]) begin
      drive(vecs[i].typ, vecs[i].rd1, vecs[i].rd2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      step();
      if (vecs[i].acc) exp_br++;
      if (vecs[i].exp_valid) exp_mp++;
      chk({vecs[i].name, "_rd_valid"}, 64'(rd_valid), 64'(vecs[i].exp_valid));
      chk({vecs[i].name, "_rd_flush"}, 64'(rd_flush), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk({vecs[i].name, "_rd_pc"}, rd_pc, vecs[i].exp_pc);
    end
    idle();
    step();
    chk("tbl_idle_valid", 64'(rd_valid), 64'd0);
    chk_stats("tbl");
    lk_pc = 64'h104;
    #1;
    chk("jalr_no_update", 64'(lk_taken), 64'd0);

    // Counter walk at 0x104: saturate up, then down, then one step up
    chk("ctr_initial", 64'(lk_taken), 64'd0);
    for (int k = 0; k < 8; k++) begin
      drive(seq_tk[k] ? BEq : BNe, 64'd1, 64'd1, 64'h104, 64'h40, seq_tk[k]);
      #1;
      if (k == 1) chk("same_cycle_old", 64'(lk_taken), 64'd1);
      step();
      exp_br++;
      chk($sformatf("ctr_step%0d", k), 64'(lk_taken), 64'(seq_exp[k]));
      chk($sformatf("ctr_noredir%0d", k), 64'(rd_valid), 64'd0);
    end
    idle();
    step();
    chk_stats("ctr");

    // Killed mispredicting bne: no redirect, no table or stat change
    drive(BNe, 64'd1, 64'd2, 64'h104, 64'h40, 1'b0);
    rs_kill = 1'b1;
    step();
    chk("kill_rd_valid", 64'(rd_valid), 64'd0);
    chk("kill_lk_taken", 64'(lk_taken), 64'd0);
    chk_stats("kill");
    rs_kill  = 1'b0;
    rs_valid = 1'b0;
    step();
    chk("novalid_rd_valid", 64'(rd_valid), 64'd0);
    chk_stats("novalid");

    // Reset right after an accepted mispredict
    drive(BJal, 64'd0, 64'd0, 64'h10, 64'h20, 1'b0);
    step();
    idle();
    chk("pre_rst_valid", 64'(rd_valid), 64'd1);
    chk("pre_rst_pc", rd_pc, 64'h30);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_flush", 64'(rd_flush), 64'd0);
    chk("mid_rst_pc", rd_pc, 64'h0);
    exp_br = 0; exp_mp = 0;
    chk_stats("mid_rst");
    lk_pc = 64'h100;
    #1;
    chk("mid_rst_lk_idx0", 64'(lk_taken), 64'd0);
    step();
    reset = 1'b1;
    step();

    // Clean start after reset: counter back at weakly-not-taken
    lk_pc = 64'h104;
    drive(BEq, 64'd5, 64'd5, 64'h104, 64'h20, 1'b0);
    step();
    exp_br++; exp_mp++;
    idle();
    chk("post_rst_valid", 64'(rd_valid), 64'd1);
    chk("post_rst_pc", rd_pc, 64'h124);
    chk_stats("post_rst");
    chk("post_rst_lk", 64'(lk_taken), 64'd1);
    step();
    chk("post_rst_end", 64'(rd_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter XLEN, default 64, sets the operand, PC and immediate width.
REQ-002 Parameter BHT_DEPTH, default 64, sets the number of prediction-table entries; it SHALL be a power of two, at least 2.
REQ-003 Parameter CTR_BITS, default 2, sets the saturating-counter width per entry.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-006 lk_pc  input  XLEN  fetch-stage lookup PC.
REQ-007 lk_taken  output  1  combinational prediction for lk_pc; 1 when the indexed counter MSB is 1.
REQ-008 rs_valid  input  1  a resolving instruction is present this cycle.
REQ-009 rs_kill  input  1  discard this cycle's resolving instruction.
REQ-010 rs_pc, rs_rd1, rs_rd2, rs_imm  input  XLEN each  instruction PC, source operands and sign-extended immediate.
REQ-011 rs_type  input  BranchType  branch kind (NoBranch, eq, ne, less_s, less_u, ge_s, ge_u, jal, jalr).
REQ-012 rs_pred  input  1  prediction fetch used for this instruction.
REQ-013 rd_valid  output  1  registered redirect request, asserted for one cycle.
REQ-014 rd_pc  output  XLEN  registered redirect target.
REQ-015 rd_flush  output  1  registered; equals rd_valid.
REQ-016 st_branches, st_mispred  output  32 each  saturating event counters.

Function
REQ-017 Accept a resolution only when rs_valid=1, rs_kill=0 and rs_type is not NoBranch; otherwise no state changes and no redirect follows.
REQ-018 Actual outcome: eq/ne SHALL use full-XLEN equality; less_s/ge_s SHALL use signed compare; less_u/ge_u SHALL use unsigned compare; jal and jalr are always taken.
REQ-019 Taken target for conditional branches and jal is rs_pc+rs_imm modulo 2^XLEN; for jalr it is (rs_rd1+rs_imm) with bit 0 cleared.
REQ-020 Fall-through target is rs_pc+4 modulo 2^XLEN.
REQ-021 Mispredict for conditional branches and jal is actual taken != rs_pred; jalr is always a mispredict.
REQ-022 On an accepted mispredict, in the next cycle rd_valid=rd_flush=1 and rd_pc is the taken target if actual taken, otherwise the fall-through target; latency is exactly 1 cycle.
REQ-023 rd_valid SHALL be 0 in any cycle not following an accepted mispredict; back-to-back mispredicts produce back-to-back pulses.
REQ-024 Table index is pc[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-025 An accepted conditional branch SHALL increment its counter when taken and decrement it when not taken, saturating at all-ones and zero; jal and jalr SHALL NOT update the table.
REQ-026 If lookup and update hit the same index in the same cycle, lk_taken SHALL reflect the pre-update value.
REQ-027 st_branches SHALL increment for each accepted resolution; st_mispred SHALL increment for each accepted mispredict; both saturate at 0xFFFFFFFF.
REQ-028 The resolution datapath SHALL have no combinational path from rs_* to rd_*.

Reset
REQ-029 While reset=0, every counter SHALL be weakly-not-taken (value 2^(CTR_BITS-1)-1, i.e. 01 for CTR_BITS=2), rd_valid=rd_flush=0, rd_pc=0, and st_* = 0.
REQ-030 Reset asserted mid-operation SHALL cancel any pending redirect in the same cycle; the first accepted resolution after deassertion behaves as from a clean start.

Verification
REQ-031 After reset, beq with rd1=rd2=5, pc=0x100, imm=0x20, pred=0 -> next cycle rd_valid=1, rd_pc=0x120; st_mispred=1.
REQ-032 bltu with rd1=1, rd2=0xFFFF_FFFF_FFFF_FFFF, pred=1 -> no redirect; blt with the same operands, pred=0 -> no redirect (signed -1 < 1 is false).
REQ-033 jalr with rd1=0x2001, imm=0x10, pred=0 -> rd_pc=0x2010; table unchanged; st_branches increments.
REQ-034 Three taken branches at the same PC -> lk_taken goes 0,1,1; its counter saturates at 11; a same-cycle lookup during the second update still reads the old value 10.
REQ-035 A mispredicting bne with rs_kill=1 -> no redirect, no table or stat change; reset pulsed the cycle after an accepted mispredict -> rd_valid drops immediately.
